// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic {ARB_CPU, ARB_FORCE} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_VGA} arb_owner_t;
    localparam int DMEM_AW = 16;
    localparam int DMEM_DW = 16;
endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// arb_wait_counter: saturating up-counter with clear, increment and terminal-count flag
module arb_wait_counter #(
    parameter int W   = 3,
    parameter int SAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = cnt == W'(SAT);
    // count up until SAT, clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !tc)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/video arbiter for the single-port data memory (stats via DMEM_ARB_STATS_EN)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   force_cnt,
`endif
    input  logic [DW-1:0] mem_q
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    arb_state_t     state, state_nxt;
    arb_owner_t     rd_owner;
    logic           rd_pend, rd_go, cpu_gnt, force_slot, wait_tc;
    logic [WW-1:0]  unused_wait_cnt;

    // video denied while CPU granted in normal mode; any grant or idle video clears
    arb_wait_counter #(.W(WW), .SAT(MAX_WAIT - 1)) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (state == ARB_FORCE || !vga_req || vga_gnt),
        .inc (state == ARB_CPU && vga_req && cpu_req),
        .cnt (unused_wait_cnt),
        .tc  (wait_tc)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ARB_CPU;
        else
            state <= state_nxt;
    end

    // a denial at the terminal wait count earns video the next slot
    always_comb begin
        state_nxt = (state == ARB_CPU && vga_req && cpu_req && wait_tc) ? ARB_FORCE : ARB_CPU;
    end

    // grant and memory-port muxing
    always_comb begin
        force_slot = state == ARB_FORCE && vga_req;
        cpu_gnt    = cpu_req && !force_slot;
        vga_gnt    = force_slot || (!cpu_req && vga_req);
        cpu_stall  = force_slot && cpu_req;
        mem_addr   = cpu_gnt ? cpu_addr : vga_gnt ? vga_addr : '0;
        mem_data   = cpu_gnt ? cpu_wdata : '0;
        mem_wren   = cpu_gnt && cpu_we;
        rd_go      = (cpu_gnt && !cpu_we) || vga_gnt;
    end

    // remember who owns the read whose data appears on mem_q next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
        end else begin
            rd_pend  <= rd_go;
            rd_owner <= vga_gnt ? OWN_VGA : OWN_CPU;
        end
    end

    assign cpu_rvalid = rd_pend && rd_owner == OWN_CPU;
    assign vga_rvalid = rd_pend && rd_owner == OWN_VGA;
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign vga_rdata  = vga_rvalid ? mem_q : '0;

`ifdef DMEM_ARB_STATS_EN
    logic unused_conflict_tc, unused_force_tc;

    arb_wait_counter #(.W(16), .SAT(16'hFFFF)) u_conflict (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (cpu_req && vga_req),
        .cnt (conflict_cnt),
        .tc  (unused_conflict_tc)
    );

    arb_wait_counter #(.W(16), .SAT(16'hFFFF)) u_force (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (force_slot),
        .cnt (force_cnt),
        .tc  (unused_force_tc)
    );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a 1-cycle memory model
module tb_dmem_arbiter;
    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_rvalid, cpu_stall;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        vga_req, vga_gnt, vga_rvalid;
    logic [15:0] vga_addr, vga_rdata;
    logic [15:0] mem_addr, mem_data, mem_q;
    logic        mem_wren;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt, force_cnt;
`endif
    logic [15:0] mem [0:65535];
    int          wr20_cnt;
    int          checks, failures;

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_stall  (cpu_stall),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt),
`endif
        .mem_q      (mem_q)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            mem[16'h0010] <= 16'hBEEF;
            mem[16'h8000] <= 16'h0F0F;
            mem[16'h0020] <= 16'h0000;
            wr20_cnt      <= 0;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_data;
            if (mem_addr == 16'h0020) wr20_cnt <= wr20_cnt + 1;
        end
        mem_q <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0;
        rst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vga_req = 0; vga_addr = 0;
        tick; tick;
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_vga_rvalid", vga_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vga_rdata", vga_rdata, 0);
        rst = 1;
        tick;
        // CPU-only load
        cpu_req = 1; cpu_addr = 16'h0010;
        #1;
        check("cpu_ld_stall", cpu_stall, 0);
        check("cpu_ld_addr", mem_addr, 16'h0010);
        check("cpu_ld_wren", mem_wren, 0);
        tick;
        cpu_req = 0;
        #1;
        check("cpu_ld_rvalid", cpu_rvalid, 1);
        check("cpu_ld_rdata", cpu_rdata, 16'hBEEF);
        check("cpu_ld_vga_rvalid", vga_rvalid, 0);
        tick;
        check("cpu_ld_rvalid_once", cpu_rvalid, 0);
        // video-only read
        vga_req = 1; vga_addr = 16'h8000;
        #1;
        check("vga_gnt", vga_gnt, 1);
        check("vga_addr", mem_addr, 16'h8000);
        tick;
        vga_req = 0;
        #1;
        check("vga_rvalid", vga_rvalid, 1);
        check("vga_rdata", vga_rdata, 16'h0F0F);
        check("vga_cpu_rvalid", cpu_rvalid, 0);
        tick;
        // both held: forced slot every fifth cycle, returns pipelined
        cpu_req = 1; cpu_addr = 16'h0010; vga_req = 1; vga_addr = 16'h8000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("both_gnt_%0d", i), vga_gnt, (i % 5) == 4);
            check($sformatf("both_stall_%0d", i), cpu_stall, (i % 5) == 4);
            check($sformatf("both_addr_%0d", i), mem_addr, (i % 5) == 4 ? 16'h8000 : 16'h0010);
            check($sformatf("both_crv_%0d", i), cpu_rvalid, i > 0 && ((i - 1) % 5) != 4);
            check($sformatf("both_vrv_%0d", i), vga_rvalid, i > 0 && ((i - 1) % 5) == 4);
            if (i == 5) check("both_vrdata", vga_rdata, 16'h0F0F);
            tick;
        end
        cpu_req = 0; vga_req = 0;
        tick;
        // forced slot collides with a store
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; vga_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("pre_force_gnt_%0d", i), vga_gnt, 0);
            tick;
        end
        cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        #1;
        check("force_st_wren", mem_wren, 0);
        check("force_st_stall", cpu_stall, 1);
        check("force_st_gnt", vga_gnt, 1);
        tick;
        vga_req = 0;
        #1;
        check("retry_st_wren", mem_wren, 1);
        check("retry_st_stall", cpu_stall, 0);
        check("retry_st_addr", mem_addr, 16'h0020);
        check("retry_st_data", mem_data, 16'h1234);
        tick;
        cpu_req = 0; cpu_we = 0;
        check("st_no_rvalid", cpu_rvalid, 0);
        tick;
        check("st_mem", mem[16'h0020], 16'h1234);
        check("st_once", wr20_cnt, 1);
        // alternating owners
        cpu_req = 1; cpu_addr = 16'h0010;
        tick;
        cpu_req = 0; vga_req = 1; vga_addr = 16'h8000;
        #1;
        check("alt_vga_gnt", vga_gnt, 1);
        check("alt_cpu_rvalid", cpu_rvalid, 1);
        check("alt_cpu_rdata", cpu_rdata, 16'hBEEF);
        check("alt_vga_rvalid0", vga_rvalid, 0);
        tick;
        vga_req = 0;
        #1;
        check("alt_vga_rvalid", vga_rvalid, 1);
        check("alt_vga_rdata", vga_rdata, 16'h0F0F);
        check("alt_cpu_rvalid0", cpu_rvalid, 0);
        check("alt_cpu_rdata0", cpu_rdata, 0);
        tick;
        // reset during a granted video read
        vga_req = 1; vga_addr = 16'h8000;
        #1;
        check("rst_rd_gnt", vga_gnt, 1);
        rst = 0;
        #1;
        check("rst_rd_rvalid_now", vga_rvalid, 0);
        tick;
        check("rst_rd_rvalid", vga_rvalid, 0);
        check("rst_rd_rdata", vga_rdata, 0);
        rst = 1;
        cpu_req = 1; cpu_addr = 16'h0010;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("post_rst_gnt_%0d", i), vga_gnt, (i % 5) == 4);
            tick;
        end
`ifdef DMEM_ARB_STATS_EN
        check("conflict_cnt", conflict_cnt, 10);
        check("force_cnt", force_cnt, 2);
`endif
        cpu_req = 0; vga_req = 0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters.
- CPU requester: the pipeline MEM stage, for loads and stores.
- Video requester: the VGA pixel fetcher, reading framebuffer words.
- CPU has priority; a starvation counter forces a video slot and stalls the pipeline for one cycle.
- Tracks the owner of the in-flight read and routes the registered memory output to that owner.

Parameters:
- AW, 16: address width in bits.
- DW, 16: data width in bits.
- MAX_WAIT, 4: number of consecutive cycles the video requester may be denied before a forced slot.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cpu_req  in  1  MEM stage memory access this cycle.
- cpu_we  in  1  store when 1, load when 0.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_stall  out  1  hold the pipeline; the CPU access was not performed.
- vga_req  in  1  pixel word read request.
- vga_addr  in  AW  framebuffer address.
- vga_gnt  out  1  video request accepted this cycle.
- vga_rdata  out  DW  pixel word.
- vga_rvalid  out  1  vga_rdata valid.
- mem_addr  out  AW  to data memory address.
- mem_data  out  DW  to data memory write data.
- mem_wren  out  1  to data memory write enable.
- mem_q  in  DW  data memory registered read data (1-cycle latency).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ARB_CPU, wait_cnt=0, rd_pend=0, rd_owner=CPU.
  - cpu_rvalid=0, vga_rvalid=0, cpu_rdata=0, vga_rdata=0.
  - Reset mid-read drops the pending read; no rvalid is ever issued for it.
- States: ARB_CPU (normal operation) and ARB_FORCE (one forced video slot).
- ARB_CPU grant decision, combinational in the same cycle:
  - cpu_req=1: CPU granted; mem_addr=cpu_addr, mem_data=cpu_wdata, mem_wren=cpu_we; cpu_stall=0.
  - cpu_req=0 and vga_req=1: video granted; mem_addr=vga_addr, mem_wren=0, vga_gnt=1.
  - Neither request: mem_wren=0, mem_addr=0.
  - wait_cnt: increments when vga_req=1 and the CPU is granted; clears on any vga_gnt or when vga_req=0.
  - When wait_cnt==MAX_WAIT-1 and the video requester is denied again, next state is ARB_FORCE.
- ARB_FORCE, exactly one cycle:
  - Video granted unconditionally if vga_req=1.
  - cpu_stall=cpu_req; the CPU access is not performed; mem_wren=0.
  - wait_cnt cleared; next state ARB_CPU.
  - If vga_req dropped before the forced slot: no grant, cpu_stall=0, CPU served normally, return to ARB_CPU.
- Read return:
  - A granted read (write disabled) sets rd_pend=1 and rd_owner for the next cycle.
  - In that next cycle, owner_rdata<=mem_q combinationally routed and owner_rvalid=1 for exactly one cycle.
  - CPU stores produce no rvalid.
- Back-to-back reads by alternating owners are fully pipelined; one return per cycle, in order.
- cpu_stall is combinational from state and cpu_req; the pipeline must freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB in that cycle.
- Address passes through unmodified; width truncation or extension is the requester's responsibility.
- vga_addr and vga_req must remain stable until vga_gnt.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs conflict_cnt[15:0] (cycles with both requests asserted) and force_cnt[15:0] (ARB_FORCE cycles with a grant).
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic {ARB_CPU, ARB_FORCE} arb_state_t.
  - typedef enum logic {OWN_CPU, OWN_VGA} arb_owner_t.
  - Default constants DMEM_AW=16, DMEM_DW=16.
- Sub-module arb_wait_counter: saturating wait counter with clear, increment and terminal-count output. It is reused by the stats counters.

Test Plan:
- CPU only, load 0x0010 with mem holding 0xBEEF: next cycle cpu_rvalid=1, cpu_rdata=0xBEEF; vga_rvalid=0; cpu_stall never asserted.
- Video only, vga_req at 0x8000 with mem 0x0F0F: vga_gnt same cycle, vga_rvalid=1 and vga_rdata=0x0F0F next cycle.
- Both held continuously, MAX_WAIT=4: CPU granted for 4 cycles, 5th cycle vga_gnt=1 and cpu_stall=1 with mem_wren=0, pattern repeats with period 5.
- Force cycle while CPU presents a store to 0x0020 with data 0x1234: store suppressed (mem_wren=0) and cpu_stall=1; store executes next cycle with mem_wren=1; memory ends at 0x1234, not written twice.
- Alternating grants CPU read A, then video read B: returns in order on consecutive cycles to the correct owner, no cross-delivery.
- Reset asserted one cycle after a video grant: vga_rvalid stays 0, state ARB_CPU, wait_cnt=0. With DMEM_ARB_STATS_EN, 10 conflict cycles give conflict_cnt=10 and force_cnt=2.
